// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: one-hot grant, address/data-phase master index,
// fixed-length burst tracking, INCR hold and locked-sequence support.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW            = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0]             BURST_INCR = 3'd1;
  localparam logic [MW-1:0]          DEF_IDX    = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT  =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default
    $error("ahb_arbiter: DEFAULT_MASTER out of range");
  end

  // Remaining beats after the NONSEQ beat; INCR has no known length.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] burst);
    logic [3:0] len_m1;
    case (burst)
      3'd0, 3'd1: len_m1 = 4'd0;
      3'd2, 3'd3: len_m1 = 4'd3;
      3'd4, 3'd5: len_m1 = 4'd7;
      3'd6, 3'd7: len_m1 = 4'd15;
      default:    len_m1 = 4'd0;
    endcase
    return len_m1;
  endfunction

  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic [MW-1:0]          hmaster_data_q, hmaster_data_d;
  logic                   hmastlock_q, hmastlock_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   incr_q, incr_d;

  logic                   rr_found_s;
  logic [MW-1:0]          rr_idx_s;
  logic [MW:0]            cand_sum_s;
  logic [MW-1:0]          cand_s;
  logic                   hit_s;
  logic                   arb_s;

  // Round-robin search from owner+1 upward, wrapping, ending at the owner.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = DEF_IDX;
    cand_sum_s = '0;
    cand_s     = '0;
    hit_s      = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand_sum_s = {1'b0, hmaster_q} + (MW+1)'(i);
      cand_sum_s = (cand_sum_s >= (MW+1)'(NUM_MASTERS)) ?
                   cand_sum_s - (MW+1)'(NUM_MASTERS) : cand_sum_s;
      cand_s     = cand_sum_s[MW-1:0];
      hit_s      = !rr_found_s && hbusreq[cand_s];
      rr_idx_s   = hit_s ? cand_s : rr_idx_s;
      rr_found_s = rr_found_s | hbusreq[cand_s];
    end
  end

  // Beat counter, lock, arbitration and data-phase pipeline; all hready-qualified.
  always_comb begin
    cnt_d          = cnt_q;
    incr_d         = incr_q;
    hmastlock_d    = hmastlock_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    arb_s          = 1'b0;
    if (hready) begin
      case (htrans)
        TR_NONSEQ: begin
          cnt_d  = burst_len_m1(hburst);
          incr_d = (hburst == BURST_INCR);
        end
        TR_SEQ:  cnt_d  = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        TR_IDLE: incr_d = 1'b0;
        default: cnt_d  = cnt_q;
      endcase
      arb_s = !hmastlock_q && !hlock[hmaster_q] && (cnt_d == 4'd0) &&
              (htrans != TR_BUSY);
      if (arb_s) begin
        // A live INCR owner still requesting counts as the sole requester.
        if (incr_d && hbusreq[hmaster_q]) begin
          hmaster_d = hmaster_q;
        end else if (rr_found_s) begin
          hmaster_d = rr_idx_s;
        end else begin
          hmaster_d = DEF_IDX;
        end
      end else begin
        hmaster_d = hmaster_q;
      end
      incr_d         = incr_d && (hmaster_d == hmaster_q);
      hmastlock_d    = hlock[hmaster_d];
      hmaster_data_d = hmaster_q;
    end else begin
      arb_s = 1'b0;
    end
  end

  // One-hot grant derived from the next owner index.
  always_comb begin
    hgrant_d            = '0;
    hgrant_d[hmaster_d] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hgrant_q       <= DEF_GRANT;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
      cnt_q          <= 4'd0;
      incr_q         <= 1'b0;
    end else begin
      hgrant_q       <= hgrant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
      cnt_q          <= cnt_d;
      incr_q         <= incr_d;
    end
  end

  assign hgrant       = hgrant_q;
  assign hmaster      = hmaster_q;
  assign hmaster_data = hmaster_data_q;
  assign hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: a behavioural arbitration model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_ahb_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic [1:0]   hmaster_data;
  logic         hmastlock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .htrans       (htrans),
    .hburst       (hburst),
    .hready       (hready),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: owner, remaining beats, lock, data-phase owner, INCR flag.
  int m_owner, m_cnt, m_data;
  bit m_lock, m_incr;

  function automatic int beats(input logic [2:0] b);
    if (b <= 3'd1) return 1;
    else if (b <= 3'd3) return 4;
    else if (b <= 3'd5) return 8;
    else return 16;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int old, nxt, c;
    bit inc, found;
    if (reset) begin
      m_owner <= 0; m_cnt <= 0; m_data <= 0; m_lock <= 1'b0; m_incr <= 1'b0;
    end else if (hready) begin
      old = m_owner; c = m_cnt; inc = m_incr; nxt = old;
      if (htrans == 2'd2) begin
        c = beats(hburst) - 1;
        inc = (hburst == 3'd1);
      end else if (htrans == 2'd3) begin
        if (c > 0) c = c - 1;
      end else if (htrans == 2'd0) begin
        inc = 1'b0;
      end
      if (!m_lock && !hlock[old] && c == 0 && htrans != 2'd1) begin
        if (!(inc && hbusreq[old])) begin
          found = 1'b0;
          nxt = 0;
          for (int k = 1; k <= N; k++) begin
            if (!found && hbusreq[(old + k) % N]) begin
              found = 1'b1;
              nxt = (old + k) % N;
            end
          end
        end
      end
      if (nxt != old) inc = 1'b0;
      m_owner <= nxt; m_cnt <= c; m_incr <= inc;
      m_lock  <= hlock[nxt];
      m_data  <= old;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("grant_model",  int'(hgrant),       1 << m_owner);
    check("master_model", int'(hmaster),      m_owner);
    check("data_model",   int'(hmaster_data), m_data);
    check("lock_model",   int'(hmastlock),    int'(m_lock));
  end

  task automatic step(input logic [3:0] req, input logic [3:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SGL = 3'd0, INCR = 3'd1, INCR4 = 3'd3;

  initial begin
    reset = 1'b1; hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SGL; hready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Release with no requests: parked on master 0.
    step(4'b0000, 4'b0000, IDLE, SGL, 1'b1);
    check("park_idle", int'(hgrant), 4'b0001);

    // Round robin with everyone requesting.
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    check("rr_g1", int'(hgrant), 4'b0010);
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    check("rr_g2", int'(hgrant), 4'b0100);
    check("rr_data", int'(hmaster_data), 1);
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    check("rr_g3", int'(hgrant), 4'b1000);
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    check("rr_g0", int'(hgrant), 4'b0001);
    check("rr_data_wrap", int'(hmaster_data), 3);
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    check("rr_pre_reset", int'(hmaster), 2);

    // Asynchronous reset mid-cycle with arbitrary inputs.
    hbusreq = 4'($urandom); hlock = 4'($urandom); htrans = 2'($urandom);
    hburst = 3'($urandom); hready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("rst_grant",  int'(hgrant),       4'b0001);
    check("rst_master", int'(hmaster),      0);
    check("rst_data",   int'(hmaster_data), 0);
    check("rst_lock",   int'(hmastlock),    0);
    step(4'b0000, 4'b0000, IDLE, SGL, 1'b1);
    reset = 1'b0;

    // Fixed-length INCR4 burst by master 2 with a wait state on beat 2.
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    check("burst_own", int'(hgrant), 4'b0100);
    step(4'b1111, 4'b0000, NSEQ, INCR4, 1'b1);
    check("burst_b1", int'(hgrant), 4'b0100);
    step(4'b1111, 4'b0000, SEQ, INCR4, 1'b1);
    check("burst_b2", int'(hgrant), 4'b0100);
    step(4'b1111, 4'b0000, SEQ, INCR4, 1'b0);
    check("burst_wait", int'(hgrant), 4'b0100);
    step(4'b1111, 4'b0000, SEQ, INCR4, 1'b1);
    check("burst_b3", int'(hgrant), 4'b0100);
    step(4'b1111, 4'b0000, SEQ, INCR4, 1'b1);
    check("burst_end", int'(hgrant), 4'b1000);
    check("burst_data", int'(hmaster_data), 2);

    // Locked sequence by master 1.
    step(4'b1110, 4'b0010, NSEQ, SGL, 1'b1);
    check("lock_grant", int'(hgrant), 4'b0010);
    check("lock_flag", int'(hmastlock), 1);
    for (int t = 0; t < 6; t++) begin
      step(4'b1111, 4'b0010, NSEQ, SGL, 1'b1);
      check("lock_hold", int'(hgrant), 4'b0010);
      check("lock_hold_flag", int'(hmastlock), 1);
    end
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    check("unlock_last", int'(hgrant), 4'b0010);
    check("unlock_flag", int'(hmastlock), 0);
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b1);
    check("unlock_move", int'(hgrant), 4'b0100);

    // Stall holds everything.
    step(4'b1111, 4'b0000, NSEQ, SGL, 1'b0);
    check("stall_hold", int'(hgrant), 4'b0100);

    // Sole requester master 3, then released to the default master.
    for (int t = 0; t < 4; t++) begin
      step(4'b1000, 4'b0000, NSEQ, SGL, 1'b1);
      check("sole_m3", int'(hgrant), 4'b1000);
    end
    step(4'b0000, 4'b0000, IDLE, SGL, 1'b1);
    check("sole_park", int'(hgrant), 4'b0001);

    // Undefined-length INCR by master 0 holds against other requesters.
    step(4'b1111, 4'b0000, NSEQ, INCR, 1'b1);
    check("incr_b1", int'(hgrant), 4'b0001);
    for (int t = 0; t < 3; t++) begin
      step(4'b1111, 4'b0000, SEQ, INCR, 1'b1);
      check("incr_hold", int'(hgrant), 4'b0001);
    end
    step(4'b1111, 4'b0000, BUSY, INCR, 1'b1);
    check("incr_busy", int'(hgrant), 4'b0001);
    step(4'b1110, 4'b0000, IDLE, INCR, 1'b1);
    check("incr_release", int'(hgrant), 4'b0010);
    check("incr_rel_data", int'(hmaster_data), 0);

    step(4'b0000, 4'b0000, IDLE, SGL, 1'b1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
